// File: rtl/axi_mem_arbiter_pkg.sv
// axi_mem_arbiter_pkg: shared FSM states and default bus widths for the memory arbiter
package axi_arb_pkg;
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP} state_e;
    localparam int ADDR_W_DEF = 7;
    localparam int DATA_W_DEF = 32;
endpackage

// File: rtl/axi_mem_arbiter_if.sv
// axi_mem_arbiter_if: master-side request channels, memory-side channels and arbiter status
interface axi_mem_arbiter_if
    import axi_arb_pkg::*;
#(
    parameter int NUM_M  = 2,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic [NUM_M*ADDR_W-1:0] m_addr;
    logic [NUM_M*DATA_W-1:0] m_wdata;
    logic [NUM_M-1:0]        m_ar_valid, m_ar_ready, m_aw_valid, m_aw_ready;
    logic [NUM_M-1:0]        m_wdata_valid, m_wdata_ready;
    logic [NUM_M-1:0]        m_rdata_valid, m_rdata_ready, m_b_valid, m_b_ready;
    logic [DATA_W-1:0]       m_rdata;
    logic [ADDR_W-1:0]       s_mem_addr;
    logic [DATA_W-1:0]       s_mem_wdata, s_mem_rdata;
    logic                    s_ar_valid, s_aw_valid, s_wdata_valid, s_rdata_ready, s_b_ready;
    logic                    s_ar_ready, s_aw_ready, s_wdata_ready, s_rdata_valid, s_b_valid;
    logic [NUM_M-1:0]        grant;
    logic                    busy;
    modport slave (
        input  m_addr, m_wdata, m_ar_valid, m_aw_valid, m_wdata_valid, m_rdata_ready, m_b_ready,
        output m_ar_ready, m_aw_ready, m_wdata_ready, m_rdata_valid, m_b_valid, m_rdata,
        output s_mem_addr, s_mem_wdata, s_ar_valid, s_aw_valid, s_wdata_valid, s_rdata_ready, s_b_ready,
        input  s_mem_rdata, s_ar_ready, s_aw_ready, s_wdata_ready, s_rdata_valid, s_b_valid,
        output grant, busy
    );
    modport master (
        output m_addr, m_wdata, m_ar_valid, m_aw_valid, m_wdata_valid, m_rdata_ready, m_b_ready,
        input  m_ar_ready, m_aw_ready, m_wdata_ready, m_rdata_valid, m_b_valid, m_rdata,
        input  s_mem_addr, s_mem_wdata, s_ar_valid, s_aw_valid, s_wdata_valid, s_rdata_ready, s_b_ready,
        output s_mem_rdata, s_ar_ready, s_aw_ready, s_wdata_ready, s_rdata_valid, s_b_valid,
        input  grant, busy
    );
endinterface

// File: rtl/axi_mem_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector starting the search just after the last winner
module rr_picker #(
    parameter int NUM_M = 2,
    parameter int IDX_W = $clog2(NUM_M)
) (
    input  logic [NUM_M-1:0] req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [NUM_M-1:0] win_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);
    logic found;
    int   j;
    always_comb begin
        win_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 1; k <= NUM_M; k++) begin
            j = (int'(last_i) + k) % NUM_M;
            if (!found && req_i[j]) begin
                found    = 1'b1;
                win_o[j] = 1'b1;
                idx_o    = IDX_W'(j);
            end
        end
    end
    assign any_o = |req_i;
endmodule

// File: rtl/axi_mem_arbiter.sv
// axi_mem_arbiter: round-robin owner of one memory slave, granting whole transactions to NUM_M masters
module axi_mem_arbiter
    import axi_arb_pkg::*;
#(
    parameter int NUM_M  = 2,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input logic              clk,
    input logic              reset,
    axi_mem_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_M);
    state_e           state_q, state_d;
    logic [NUM_M-1:0] grant_q, grant_d, win_oh;
    logic [IDX_W-1:0] g_q, g_d, last_q, last_d, win_idx;
    logic             any_req;
    rr_picker #(.NUM_M(NUM_M), .IDX_W(IDX_W)) u_pick (
        .req_i (bus.m_ar_valid | bus.m_aw_valid),
        .last_i(last_q),
        .win_o (win_oh),
        .idx_o (win_idx),
        .any_o (any_req)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            g_q     <= '0;
            last_q  <= IDX_W'(NUM_M - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            g_q     <= g_d;
            last_q  <= last_d;
        end
    end
    // Only the granted master's channel for the current phase is ever connected through.
    always_comb begin
        state_d           = state_q;
        grant_d           = grant_q;
        g_d               = g_q;
        last_d            = last_q;
        bus.m_ar_ready    = '0;
        bus.m_aw_ready    = '0;
        bus.m_wdata_ready = '0;
        bus.m_rdata_valid = '0;
        bus.m_b_valid     = '0;
        bus.s_ar_valid    = 1'b0;
        bus.s_aw_valid    = 1'b0;
        bus.s_wdata_valid = 1'b0;
        bus.s_rdata_ready = 1'b0;
        bus.s_b_ready     = 1'b0;
        bus.s_mem_wdata   = '0;
        bus.s_mem_addr    = state_q != IDLE ? bus.m_addr[int'(g_q)*ADDR_W +: ADDR_W] : '0;
        case (state_q)
            IDLE: if (any_req) begin
                grant_d = win_oh;
                g_d     = win_idx;
                state_d = bus.m_aw_valid[win_idx] ? WR_ADDR : RD_ADDR;
            end
            RD_ADDR: begin
                bus.s_ar_valid      = bus.m_ar_valid[g_q];
                bus.m_ar_ready[g_q] = bus.s_ar_ready;
                if (bus.m_ar_valid[g_q] && bus.s_ar_ready) state_d = RD_DATA;
            end
            RD_DATA: begin
                bus.m_rdata_valid[g_q] = bus.s_rdata_valid;
                bus.s_rdata_ready      = bus.m_rdata_ready[g_q];
                if (bus.s_rdata_valid && bus.m_rdata_ready[g_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                    last_d  = g_q;
                end
            end
            WR_ADDR: begin
                bus.s_aw_valid      = bus.m_aw_valid[g_q];
                bus.m_aw_ready[g_q] = bus.s_aw_ready;
                if (bus.m_aw_valid[g_q] && bus.s_aw_ready) state_d = WR_DATA;
            end
            WR_DATA: begin
                bus.s_wdata_valid      = bus.m_wdata_valid[g_q];
                bus.m_wdata_ready[g_q] = bus.s_wdata_ready;
                bus.s_mem_wdata        = bus.m_wdata[int'(g_q)*DATA_W +: DATA_W];
                if (bus.m_wdata_valid[g_q] && bus.s_wdata_ready) state_d = WR_RESP;
            end
            WR_RESP: begin
                bus.m_b_valid[g_q] = bus.s_b_valid;
                bus.s_b_ready      = bus.m_b_ready[g_q];
                if (bus.s_b_valid && bus.m_b_ready[g_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                    last_d  = g_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    assign bus.m_rdata = bus.s_mem_rdata;
    assign bus.grant   = grant_q;
    assign bus.busy    = state_q != IDLE;
endmodule

// File: tb/tb_axi_mem_arbiter.sv
// tb_axi_mem_arbiter: directed per-cycle vector table plus hand-written corner sequences
module tb_axi_mem_arbiter;
    import axi_arb_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    always #5 clk = ~clk;
    axi_mem_arbiter_if #(.NUM_M(2), .ADDR_W(7), .DATA_W(32)) bus ();
    axi_mem_arbiter #(.NUM_M(2), .ADDR_W(7), .DATA_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));
    // inputs:   {ar_v, aw_v, w_v, r_rdy, b_rdy, s_ar_rdy, s_aw_rdy, s_w_rdy, s_r_v, s_b_v}
    // expected: {grant, busy, ar_rdy, aw_rdy, w_rdy, r_v, b_v, s_ar_v, s_aw_v, s_w_v, s_r_rdy, s_b_rdy}
    typedef struct {
        logic [14:0] in;
        logic [17:0] exp;
        logic [6:0]  addr;
    } vec_t;
    vec_t tbl[$];
    logic [17:0] obs;
    assign obs = {bus.grant, bus.busy, bus.m_ar_ready, bus.m_aw_ready, bus.m_wdata_ready,
                  bus.m_rdata_valid, bus.m_b_valid, bus.s_ar_valid, bus.s_aw_valid,
                  bus.s_wdata_valid, bus.s_rdata_ready, bus.s_b_ready};
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask
    task automatic apply(input logic [14:0] v);
        {bus.m_ar_valid, bus.m_aw_valid, bus.m_wdata_valid, bus.m_rdata_ready, bus.m_b_ready,
         bus.s_ar_ready, bus.s_aw_ready, bus.s_wdata_ready, bus.s_rdata_valid, bus.s_b_valid} = v;
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    initial begin
        bus.m_addr      = {7'h7F, 7'h12};
        bus.m_wdata     = {32'hA5A5A5A5, 32'h11112222};
        bus.s_mem_rdata = 32'hDEADBEEF;
        apply(15'b00_00_00_11_11_11100);
        // M0 read with two rdata wait cycles
        tbl.push_back('{15'b01_00_00_11_11_11100, 18'b00_0_00_00_00_00_00_00000, 7'h00});
        tbl.push_back('{15'b01_00_00_11_11_11100, 18'b01_1_01_00_00_00_00_10000, 7'h12});
        tbl.push_back('{15'b00_00_00_11_11_11100, 18'b01_1_00_00_00_00_00_00010, 7'h12});
        tbl.push_back('{15'b00_00_00_11_11_11100, 18'b01_1_00_00_00_00_00_00010, 7'h12});
        tbl.push_back('{15'b00_00_00_11_11_11110, 18'b01_1_00_00_00_01_00_00010, 7'h12});
        tbl.push_back('{15'b00_00_00_11_11_11100, 18'b00_0_00_00_00_00_00_00000, 7'h00});
        // M1 write, zero-wait slave
        tbl.push_back('{15'b00_10_10_11_11_11100, 18'b00_0_00_00_00_00_00_00000, 7'h00});
        tbl.push_back('{15'b00_10_10_11_11_11100, 18'b10_1_00_10_00_00_00_01000, 7'h7F});
        tbl.push_back('{15'b00_00_10_11_11_11100, 18'b10_1_00_00_10_00_00_00100, 7'h7F});
        tbl.push_back('{15'b00_00_00_11_11_11101, 18'b10_1_00_00_00_00_10_00001, 7'h7F});
        tbl.push_back('{15'b00_00_00_11_11_11100, 18'b00_0_00_00_00_00_00_00000, 7'h00});
        // both masters reading continuously: M0, M1, M0 with one IDLE cycle between
        tbl.push_back('{15'b11_00_00_11_11_11110, 18'b00_0_00_00_00_00_00_00000, 7'h00});
        tbl.push_back('{15'b11_00_00_11_11_11110, 18'b01_1_01_00_00_00_00_10000, 7'h12});
        tbl.push_back('{15'b11_00_00_11_11_11110, 18'b01_1_00_00_00_01_00_00010, 7'h12});
        tbl.push_back('{15'b11_00_00_11_11_11110, 18'b00_0_00_00_00_00_00_00000, 7'h00});
        tbl.push_back('{15'b11_00_00_11_11_11110, 18'b10_1_10_00_00_00_00_10000, 7'h7F});
        tbl.push_back('{15'b11_00_00_11_11_11110, 18'b10_1_00_00_00_10_00_00010, 7'h7F});
        tbl.push_back('{15'b11_00_00_11_11_11110, 18'b00_0_00_00_00_00_00_00000, 7'h00});
        tbl.push_back('{15'b11_00_00_11_11_11110, 18'b01_1_01_00_00_00_00_10000, 7'h12});
        tbl.push_back('{15'b00_00_00_11_11_11110, 18'b01_1_00_00_00_01_00_00010, 7'h12});
        tbl.push_back('{15'b00_00_00_11_11_11100, 18'b00_0_00_00_00_00_00_00000, 7'h00});
        #12;
        chk("reset_outputs", 32'(obs), 32'h0);
        chk("reset_addr", 32'(bus.s_mem_addr), 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        chk("m_rdata_broadcast", bus.m_rdata, 32'hDEADBEEF);
        foreach (tbl[i]) begin
            apply(tbl[i].in);
            #1;
            chk($sformatf("vec%0d_outputs", i), 32'(obs), 32'(tbl[i].exp));
            chk($sformatf("vec%0d_addr", i), 32'(bus.s_mem_addr), 32'(tbl[i].addr));
            if (bus.s_wdata_valid) chk($sformatf("vec%0d_wdata", i), bus.s_mem_wdata, 32'hA5A5A5A5);
            cyc();
        end
        // M0 requests write and read together: write first, read on the next arbitration
        bus.m_ar_valid = 2'b01; bus.m_aw_valid = 2'b01; bus.m_wdata_valid = 2'b01;
        #1 chk("t4_idle_grant", 32'(bus.grant), 32'h0);
        cyc();
        chk("t4_aw_not_ar", 32'({bus.s_aw_valid, bus.s_ar_valid}), 32'h2);
        chk("t4_aw_grant", 32'(bus.grant), 32'h1);
        cyc();
        bus.m_aw_valid = 2'b00;
        #1 chk("t4_w_valid", 32'(bus.s_wdata_valid), 32'h1);
        chk("t4_wdata", bus.s_mem_wdata, 32'h11112222);
        cyc();
        bus.m_wdata_valid = 2'b00; bus.s_b_valid = 1'b1;
        #1 chk("t4_b_valid", 32'(bus.m_b_valid), 32'h1);
        cyc();
        bus.s_b_valid = 1'b0;
        #1 chk("t4_idle_between", 32'({bus.busy, bus.grant}), 32'h0);
        cyc();
        chk("t4_read_phase", 32'({bus.grant, bus.s_ar_valid, bus.s_aw_valid}), 32'h6);
        cyc();
        bus.m_ar_valid = 2'b00; bus.s_rdata_valid = 1'b1;
        #1 chk("t4_rdata_valid", 32'(bus.m_rdata_valid), 32'h1);
        cyc();
        bus.s_rdata_valid = 1'b0;
        #1 chk("t4_done", 32'(bus.busy), 32'h0);
        // asynchronous reset in the middle of WR_DATA
        bus.m_aw_valid = 2'b10; bus.m_wdata_valid = 2'b10;
        cyc();
        cyc();
        bus.m_aw_valid = 2'b00;
        #1 chk("t5_in_wr_data", 32'({bus.grant, bus.s_wdata_valid}), 32'h5);
        reset = 1'b1;
        #1 chk("t5_async_outputs", 32'(obs), 32'h0);
        chk("t5_async_addr", 32'(bus.s_mem_addr), 32'h0);
        chk("t5_async_wdata", bus.s_mem_wdata, 32'h0);
        cyc();
        reset = 1'b0; bus.m_wdata_valid = 2'b00;
        cyc();
        bus.m_ar_valid = 2'b10;
        #1 chk("t5_idle", 32'(bus.busy), 32'h0);
        cyc();
        chk("t5_m1_grant", 32'(bus.grant), 32'h2);
        chk("t5_m1_read", 32'({bus.s_ar_valid, bus.m_ar_ready}), 32'h6);
        chk("t5_m1_addr", 32'(bus.s_mem_addr), 32'h7F);
        cyc();
        bus.m_ar_valid = 2'b00; bus.s_rdata_valid = 1'b1;
        #1 chk("t5_rdata_valid", 32'(bus.m_rdata_valid), 32'h2);
        cyc();
        bus.s_rdata_valid = 1'b0;
        // M0 read stalled 5 cycles in RD_DATA while M1 holds its request
        bus.m_ar_valid = 2'b11;
        cyc();
        chk("t6_m0_grant", 32'(bus.grant), 32'h1);
        cyc();
        bus.m_ar_valid = 2'b10;
        for (int i = 0; i < 5; i++) begin
            #1 chk($sformatf("t6_stall%0d_ready", i), 32'({bus.grant, bus.m_ar_ready, bus.m_rdata_valid}), 32'h10);
            chk($sformatf("t6_stall%0d_addr", i), 32'(bus.s_mem_addr), 32'h12);
            cyc();
        end
        bus.s_rdata_valid = 1'b1;
        #1 chk("t6_rdata_valid", 32'(bus.m_rdata_valid), 32'h1);
        cyc();
        bus.s_rdata_valid = 1'b0;
        #1 chk("t6_idle", 32'({bus.busy, bus.grant}), 32'h0);
        cyc();
        chk("t6_m1_grant", 32'({bus.grant, bus.m_ar_ready}), 32'ha);
        chk("t6_m1_addr", 32'(bus.s_mem_addr), 32'h7F);
        bus.m_ar_valid = 2'b00;
        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
